accel_dispatch: RTL

Accelerator-side responder for the CPU's hash/encrypt/decrypt interrupt interface. It captures `H_int`/`E_int`/`D_int` rising edges together with the 11-bit `index` and queues one pending request per operation. It dispatches requests one at a time to the shared crypto engine through a request/grant/finish handshake. It returns a one-cycle `H_done`/`E_done`/`D_done` pulse to the CPU when the engine finishes. It sits between the CPU top level and the crypto engine datapath.

---
 rtl/accel_dispatch.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/accel_dispatch.sv
// -----------------------------------------------------------------------------
// accel_dispatch
//
// Accelerator-side responder for the CPU hash/encrypt/decrypt interrupt lines.
// It detects rising edges on H_int/E_int/D_int and captures the 11-bit index
// for each one. It keeps one pending request per operation and hands them one
// at a time to the shared crypto engine. When the engine finishes, it returns
// a one-cycle done pulse to the CPU.
//
// Optional feature: define ACCEL_DISPATCH_TIMEOUT_EN to enable a RUN-state
// watchdog. After TIMEOUT_CYCLES cycles in RUN without eng_fin, the run is
// aborted. The done pulse is still issued and the sticky timeout_err flag is
// set. Without the macro, RUN waits for eng_fin indefinitely and timeout_err
// is tied to 0.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   H_int/E_int/D_int    CPU request levels (rising edge = event)
//   index[10:0]          data-memory index captured with the event
//   H_done/E_done/D_done one-cycle completion pulses to the CPU
//   eng_req              request to the engine, held until eng_gnt
//   eng_op[1:0]          00 hash, 01 encrypt, 10 decrypt
//   eng_index[10:0]      index of the active operation
//   eng_gnt, eng_fin     engine grant (seen in REQ) / finish (seen in RUN)
//   overrun              sticky: event for an op that was already pending
//   timeout_err          sticky: engine run aborted by the watchdog
//   dbgState[1:0]        FSM state (0 IDLE, 1 REQ, 2 RUN, 3 DONE)
//
// Engine handshake: eng_req acts as "valid" and eng_gnt as "ready". The
// transfer happens on the rising edge where both are high. eng_req,
// eng_op and eng_index do not change while eng_req is waiting. They also
// stay stable through RUN until the engine returns a one-cycle eng_fin.
// -----------------------------------------------------------------------------
module accel_dispatch #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        H_int,
   input  logic        E_int,
   input  logic        D_int,
   input  logic [10:0] index,
   output logic        H_done,
   output logic        E_done,
   output logic        D_done,
   output logic        eng_req,
   output logic [1:0]  eng_op,
   output logic [10:0] eng_index,
   input  logic        eng_gnt,
   input  logic        eng_fin,
   output logic        overrun,
   output logic        timeout_err,
   output logic [1:0]  dbgState
);

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
      $error("accel_dispatch: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e      state;
   logic [1:0]  curOp;
   logic [2:0]  doneVec;     // bit 0 hash, bit 1 encrypt, bit 2 decrypt
   logic [2:0]  intNow;
   logic [2:0]  intQ;
   logic [2:0]  evt;
   logic [2:0]  pend;
   logic [2:0]  finVec;
   logic [10:0] idx [3];
   logic [1:0]  selOp;
   logic [10:0] selIdx;

   assign intNow = {D_int, E_int, H_int};
   assign evt    = intNow & ~intQ;

   // The op currently in DONE gives up its pending bit on this edge, so a
   // new event for that op reloads it instead of counting as an overrun.
   assign finVec = (state == DONE) ? (3'b001 << curOp) : 3'b000;

   // Fixed priority H > E > D.
   always_comb begin
      selOp  = 2'd0;
      selIdx = idx[0];
      if (pend[0]) begin
         selOp  = 2'd0;
         selIdx = idx[0];
      end else if (pend[1]) begin
         selOp  = 2'd1;
         selIdx = idx[1];
      end else begin
         selOp  = 2'd2;
         selIdx = idx[2];
      end
   end

   // Edge detect, request capture and overrun tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         intQ    <= 3'b000;
         pend    <= 3'b000;
         overrun <= 1'b0;
         for (int i = 0; i < 3; i++) idx[i] <= 11'd0;
      end else begin
         intQ <= intNow;
         pend <= (pend & ~finVec) | evt;
         for (int i = 0; i < 3; i++) begin
            if (evt[i] && (!pend[i] || finVec[i])) idx[i] <= index;
         end
         if (|(evt & pend & ~finVec)) overrun <= 1'b1;
      end
   end

`ifdef ACCEL_DISPATCH_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] runCnt;
   logic        timeoutErr;
   assign timeout_err = timeoutErr;
`else
   assign timeout_err = 1'b0;
`endif

   // Dispatch FSM. All engine-facing and CPU-facing outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         curOp     <= 2'd0;
         eng_req   <= 1'b0;
         eng_op    <= 2'd0;
         eng_index <= 11'd0;
         doneVec   <= 3'b000;
`ifdef ACCEL_DISPATCH_TIMEOUT_EN
         runCnt     <= 16'd0;
         timeoutErr <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|pend) begin
                  state     <= REQ;
                  curOp     <= selOp;
                  eng_req   <= 1'b1;
                  eng_op    <= selOp;
                  eng_index <= selIdx;
               end
            end
            REQ: begin
               if (eng_gnt) begin
                  state   <= RUN;
                  eng_req <= 1'b0;
`ifdef ACCEL_DISPATCH_TIMEOUT_EN
                  runCnt  <= 16'd0;
`endif
               end
            end
            RUN: begin
               if (eng_fin) begin
                  state   <= DONE;
                  doneVec <= 3'b001 << curOp;
`ifdef ACCEL_DISPATCH_TIMEOUT_EN
               end else if (runCnt == TO_LAST) begin
                  // Abort the run but still answer the CPU.
                  state      <= DONE;
                  doneVec    <= 3'b001 << curOp;
                  timeoutErr <= 1'b1;
               end else begin
                  runCnt <= runCnt + 16'd1;
`endif
               end
            end
            DONE: begin
               state   <= IDLE;
               doneVec <= 3'b000;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign H_done   = doneVec[0];
   assign E_done   = doneVec[1];
   assign D_done   = doneVec[2];
   assign dbgState = state;

endmodule
